id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and operand-select stage that feeds the 32-bit ALU. It captures one decoded instruction per cycle from the decode stage and resolves forwarding from the EX/MEM and MEM/WB stages. It presents the final `A`, `B` and `ALU_Ctr` operands to the ALU, detects load-use hazards, and supports stall, flush and bubble insertion.

## Interface
- `ZERO_REG`, default 5'd0: register index that is hard-wired zero and never forwarded.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode stage presents a valid instruction.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm32` in 32: extended immediate. For LUI this is the raw 16-bit immediate, zero-extended.
- `id_rs`, `id_rt`, `id_rd` in 5: source and destination register indices.
- `id_alu_ctr` in 3: ALU opcode. ADD=000, SUB=100, AND=001, OR=010, XOR=101, LUI=110.
- `id_alu_src` in 1: 1 selects the immediate for B.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: control bits.
- `stall` in 1: downstream hold request.
- `flush` in 1: kill the instruction in this stage and the one being captured.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_data` in 32: MEM/WB forwarding source.
- `A`, `B` out 32: ALU operands.
- `ALU_Ctr` out 3: ALU opcode.
- `ex_valid` out 1: this stage holds a live instruction.
- `ex_rd` out 5, `ex_store_data` out 32: destination register and forwarded rt for stores.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: registered control, each gated by `ex_valid`.
- `load_use_stall` out 1: tells fetch and decode to hold this cycle.

## Operation
- **Registered state:** valid, rs_data, rt_data, imm32, rs, rt, rd, alu_ctr, alu_src and the four control bits.
- **Per-edge priority:**
  1. `flush` clears valid to 0; other fields may hold.
  2. Else `stall` holds all registers.
  3. Else `load_use_stall` loads a bubble: valid=0, all control bits 0, ALU_Ctr=000.
  4. Else load all fields from the `id_*` inputs, with valid=`id_valid`.
- **Load-use hazard:**
  - `load_use_stall` = `ex_valid` & registered mem_read & `id_valid` & (ex rd != `ZERO_REG`) & (ex rd == `id_rs` | ex rd == `id_rt`).
  - It is combinational, and it is forced to 0 while `flush` is high.
- **Forwarding, evaluated per source (rs, rt) on the registered indices:**
  - If `exmem_reg_write` & `exmem_rd` == src & src != `ZERO_REG`, the value is `exmem_result`.
  - Else if `memwb_reg_write` & `memwb_rd` == src & src != `ZERO_REG`, the value is `memwb_data`.
  - Else the value is the registered register-file data.
  - EX/MEM always wins over MEM/WB.
- **Operand outputs:**
  - `A` = forwarded rs.
  - `B` = alu_src ? imm32 : forwarded rt.
  - `ex_store_data` = forwarded rt, regardless of alu_src.
  - `ALU_Ctr` = registered alu_ctr.
- **Bubble outputs:** when valid=0, all `ex_*` control outputs are 0 and `ALU_Ctr`=000. `A` and `B` are don't-care.

## Timing
- **Reset:** while `rst_n`=0, every register clears asynchronously. The outputs then read as follows:
  - `ex_valid`=0 and `ALU_Ctr`=000.
  - `A`=`B`=0, unless a forwarding input matches index 0, which it cannot.
  - `ex_rd`=0, `ex_store_data`=0, all control outputs 0, `load_use_stall`=0.
- **Capture latency:** one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- **Forwarding path:** combinational, within the same cycle. It adds no latency.
- **Load-use penalty:** exactly one bubble. On the next edge the load has moved to MEM, the hazard clears, and the held decode instruction is captured. Its operand is then forwarded from MEM/WB on the following cycle.
- **Stall with hazard:** `stall` and `load_use_stall` both high means hold. No bubble is inserted.
- **Flush:** `flush` overrides everything, including a simultaneous `stall`.
- **Reset mid-stall or mid-bubble:** returns to the reset state immediately.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-operation. Required: all outputs 0 at once, `ex_valid`=0.
2. **Basic capture:**
   - Stimulus: `id_rs_data`=5, `id_rt_data`=3, `id_alu_ctr`=100, `id_alu_src`=0, no forwarding.
   - Required, one cycle later: `A`=5, `B`=3, `ALU_Ctr`=100, `ex_valid`=1.
   - Repeat with alu_src=1, imm=0x1234, LUI. Required: `B`=0x00001234.
3. **Forward priority:**
   - Stimulus: registered rs=7. EX/MEM writes r7 with 0xAAAA. MEM/WB writes r7 with 0xBBBB.
   - Required: `A`=0xAAAA. Drop `exmem_reg_write` and require `A`=0xBBBB.
   - With rs=0 and both sources targeting r0, `A` must equal the registered data.
4. **Load-use:**
   - Stimulus: `lw r4` in this stage, decode presents `add` using r4.
   - Required: `load_use_stall`=1 for exactly one cycle, and a bubble is inserted with all control bits 0.
   - The add is captured on the next edge, and `A` is then taken from `memwb_data`.
5. **Stall and flush:**
   - Hold `stall` for 3 cycles while the `id_*` inputs change. Required: outputs unchanged.
   - Assert `flush` and `stall` together. Required: `ex_valid`=0 next cycle and `load_use_stall`=0.
6. **Store data:** `sw` with alu_src=1, rt=9 and EX/MEM writing r9=0x55. Required: `B`=imm and `ex_store_data`=0x55.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Presents A, B and ALU_Ctr to the 32-bit ALU one cycle after decode.
module id_ex_stage #(
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm32,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_alu_ctr,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALU_Ctr,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        load_use_stall
);

    logic        valid_reg;
    logic [31:0] rs_data_reg;
    logic [31:0] rt_data_reg;
    logic [31:0] imm32_reg;
    logic [4:0]  rs_reg;
    logic [4:0]  rt_reg;
    logic [4:0]  rd_reg;
    logic [2:0]  alu_ctr_reg;
    logic        alu_src_reg;
    logic        reg_write_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        mem_to_reg_reg;

    logic [1:0][4:0]  src_idx;
    logic [1:0][31:0] src_data;
    logic [1:0][31:0] fwd_data;

    // A load in this stage whose destination is read by the decoding instruction
    // must wait one cycle so its data can come back through MEM/WB.
    assign load_use_stall = ~flush & valid_reg & mem_read_reg & id_valid
                          & (rd_reg != ZERO_REG)
                          & ((rd_reg == id_rs) | (rd_reg == id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            rs_data_reg    <= '0;
            rt_data_reg    <= '0;
            imm32_reg      <= '0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            rd_reg         <= '0;
            alu_ctr_reg    <= '0;
            alu_src_reg    <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (stall) begin
            valid_reg <= valid_reg;
        end else if (load_use_stall) begin
            valid_reg      <= 1'b0;
            alu_ctr_reg    <= '0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else begin
            valid_reg      <= id_valid;
            rs_data_reg    <= id_rs_data;
            rt_data_reg    <= id_rt_data;
            imm32_reg      <= id_imm32;
            rs_reg         <= id_rs;
            rt_reg         <= id_rt;
            rd_reg         <= id_rd;
            alu_ctr_reg    <= id_alu_ctr;
            alu_src_reg    <= id_alu_src;
            reg_write_reg  <= id_reg_write;
            mem_read_reg   <= id_mem_read;
            mem_write_reg  <= id_mem_write;
            mem_to_reg_reg <= id_mem_to_reg;
        end
    end

    assign src_idx  = {rt_reg, rs_reg};
    assign src_data = {rt_data_reg, rs_data_reg};

    // Index 0 is rs, index 1 is rt; the younger EX/MEM result takes priority.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_data[gi] =
                (exmem_reg_write && exmem_rd == src_idx[gi] && src_idx[gi] != ZERO_REG) ? exmem_result :
                (memwb_reg_write && memwb_rd == src_idx[gi] && src_idx[gi] != ZERO_REG) ? memwb_data :
                src_data[gi];
        end
    endgenerate

    assign A             = fwd_data[0];
    assign B             = alu_src_reg ? imm32_reg : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign ex_rd         = rd_reg;
    assign ex_valid      = valid_reg;
    assign ALU_Ctr       = valid_reg ? alu_ctr_reg : 3'b000;
    assign ex_reg_write  = valid_reg & reg_write_reg;
    assign ex_mem_read   = valid_reg & mem_read_reg;
    assign ex_mem_write  = valid_reg & mem_write_reg;
    assign ex_mem_to_reg = valid_reg & mem_to_reg_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected values tagged with
// the cycle they are due, a negedge monitor pops and compares them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm32;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_ctr;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic [31:0] A, B, ex_store_data;
    logic [2:0]  ALU_Ctr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic        load_use_stall;

    id_ex_stage #(.ZERO_REG(5'd0)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .A(A), .B(B), .ALU_Ctr(ALU_Ctr), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef enum int {S_A, S_B, S_CTR, S_VALID, S_RD, S_SD, S_RW, S_MR, S_MW, S_MTR, S_LUS} sig_e;
    typedef struct {
        int          at;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t keep_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            S_A:     return A;
            S_B:     return B;
            S_CTR:   return {29'd0, ALU_Ctr};
            S_VALID: return {31'd0, ex_valid};
            S_RD:    return {27'd0, ex_rd};
            S_SD:    return ex_store_data;
            S_RW:    return {31'd0, ex_reg_write};
            S_MR:    return {31'd0, ex_mem_read};
            S_MW:    return {31'd0, ex_mem_write};
            S_MTR:   return {31'd0, ex_mem_to_reg};
            default: return {31'd0, load_use_stall};
        endcase
    endfunction

    // Monitor: compares every entry due in this cycle at the falling edge.
    always @(negedge clk) begin
        logic [31:0] act;
        keep_q.delete();
        foreach (sb[i]) begin
            if (sb[i].at == cyc) begin
                act = actual(sb[i].sig);
                n_chk++;
                if (act !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", sb[i].name, cyc, act, sb[i].val);
                end
            end else if (sb[i].at < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: check for cyc %0d never ran (got n/a expected 0x%08h)", sb[i].name, sb[i].at, sb[i].val);
            end else begin
                keep_q.push_back(sb[i]);
            end
        end
        sb = keep_q;
    end

    task automatic exp_at(int at, sig_e s, logic [31:0] v, string n);
        exp_t e;
        e.at = at; e.sig = s; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic exp_now(sig_e s, logic [31:0] v, string n);
        exp_at(cyc, s, v, n);
    endtask

    task automatic exp_next(sig_e s, logic [31:0] v, string n);
        exp_at(cyc + 1, s, v, n);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_id(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [2:0] ctr, input logic src,
                            input logic rw, input logic mr, input logic mw, input logic mtr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm32 = imm;
        id_alu_ctr = ctr; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mtr;
        $display("[cyc %0d] decode %s rs=%0d rt=%0d rd=%0d ctr=%03b src=%0b", cyc, tag, rs, rt, rd, ctr, src);
    endtask

    task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] md);
        exmem_reg_write = ew; exmem_rd = erd; exmem_result = er;
        memwb_reg_write = mw; memwb_rd = mrd; memwb_data = md;
    endtask

    task automatic exp_reset_state(string n);
        exp_now(S_VALID, 0, {n, "_valid"});
        exp_now(S_A, 0, {n, "_A"});
        exp_now(S_B, 0, {n, "_B"});
        exp_now(S_CTR, 0, {n, "_ctr"});
        exp_now(S_RD, 0, {n, "_rd"});
        exp_now(S_SD, 0, {n, "_sd"});
        exp_now(S_RW, 0, {n, "_rw"});
        exp_now(S_MR, 0, {n, "_mr"});
        exp_now(S_LUS, 0, {n, "_lus"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id("idle", 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        fwd(0, 0, 0, 0, 0, 0);

        // Reset state
        step();
        exp_reset_state("reset");
        step();
        rst_n = 1'b1;

        // Basic capture: SUB then LUI with immediate
        drive_id("sub", 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 3'b100, 0, 1, 0, 0, 0);
        exp_next(S_A, 32'd5, "sub_A");
        exp_next(S_B, 32'd3, "sub_B");
        exp_next(S_CTR, 32'd4, "sub_ctr");
        exp_next(S_VALID, 1, "sub_valid");
        exp_next(S_RD, 32'd3, "sub_rd");
        exp_next(S_RW, 1, "sub_rw");
        step();
        drive_id("lui", 1, 5'd1, 5'd2, 5'd4, 32'd0, 32'd3, 32'h1234, 3'b110, 1, 1, 0, 0, 0);
        exp_next(S_B, 32'h0000_1234, "lui_B");
        exp_next(S_CTR, 32'd6, "lui_ctr");
        exp_next(S_RD, 32'd4, "lui_rd");
        step();

        // Forward priority on rs=7
        drive_id("add_r7", 1, 5'd7, 5'd2, 5'd5, 32'h11, 32'h22, 32'd0, 3'b000, 0, 1, 0, 0, 0);
        step();
        fwd(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
        exp_now(S_A, 32'hAAAA, "fwd_exmem_wins");
        exp_now(S_B, 32'h22, "fwd_rt_unmatched");
        step();
        fwd(0, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
        exp_now(S_A, 32'hBBBB, "fwd_memwb");
        step();
        fwd(0, 0, 0, 0, 0, 0);
        exp_now(S_A, 32'h11, "fwd_none");

        // Zero register is never forwarded
        drive_id("add_r0", 1, 5'd0, 5'd0, 5'd5, 32'h77, 32'h66, 32'd0, 3'b000, 0, 1, 0, 0, 0);
        step();
        fwd(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
        exp_now(S_A, 32'h77, "zero_reg_A");
        exp_now(S_B, 32'h66, "zero_reg_B");
        step();
        fwd(0, 0, 0, 0, 0, 0);

        // Load-use: lw r4 then add using r4
        drive_id("lw_r4", 1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'd8, 3'b000, 1, 1, 1, 0, 1);
        step();
        drive_id("add_r4", 1, 5'd4, 5'd2, 5'd6, 32'h999, 32'h10, 32'd0, 3'b000, 0, 1, 0, 0, 0);
        exp_now(S_LUS, 1, "lu_stall_hi");
        exp_now(S_A, 32'h100, "lw_A");
        exp_now(S_B, 32'd8, "lw_B");
        exp_now(S_MR, 1, "lw_mr");
        exp_now(S_MTR, 1, "lw_mtr");
        step();
        exp_now(S_VALID, 0, "bubble_valid");
        exp_now(S_RW, 0, "bubble_rw");
        exp_now(S_MR, 0, "bubble_mr");
        exp_now(S_MTR, 0, "bubble_mtr");
        exp_now(S_CTR, 0, "bubble_ctr");
        exp_now(S_LUS, 0, "lu_stall_one_cycle");
        step();
        fwd(0, 0, 0, 1, 5'd4, 32'hCAFE);
        exp_now(S_VALID, 1, "lu_add_valid");
        exp_now(S_A, 32'hCAFE, "lu_add_A_memwb");
        exp_now(S_B, 32'h10, "lu_add_B");
        exp_now(S_RD, 32'd6, "lu_add_rd");
        exp_now(S_LUS, 0, "lu_after");
        step();
        fwd(0, 0, 0, 0, 0, 0);

        // Stall for three cycles while decode inputs change
        drive_id("xor_x", 1, 5'd3, 5'd5, 5'd7, 32'h3333, 32'h5555, 32'd0, 3'b101, 0, 1, 0, 0, 0);
        step();
        stall = 1'b1;
        drive_id("or_y", 1, 5'd8, 5'd10, 5'd9, 32'hFFFF, 32'h1, 32'd0, 3'b010, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            exp_now(S_A, 32'h3333, $sformatf("stall%0d_A", k));
            exp_now(S_B, 32'h5555, $sformatf("stall%0d_B", k));
            exp_now(S_CTR, 32'd5, $sformatf("stall%0d_ctr", k));
            exp_now(S_RD, 32'd7, $sformatf("stall%0d_rd", k));
            exp_now(S_VALID, 1, $sformatf("stall%0d_valid", k));
            if (k < 3) step();
        end
        stall = 1'b0;
        exp_next(S_A, 32'hFFFF, "post_stall_A");
        exp_next(S_CTR, 32'd2, "post_stall_ctr");
        exp_next(S_RD, 32'd9, "post_stall_rd");
        step();

        // Stall with hazard holds, then flush with stall kills
        drive_id("lw2_r4", 1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'd4, 3'b000, 1, 1, 1, 0, 1);
        step();
        drive_id("add2_r4", 1, 5'd2, 5'd4, 5'd6, 32'h1, 32'h2, 32'd0, 3'b000, 0, 1, 0, 0, 0);
        stall = 1'b1;
        exp_now(S_LUS, 1, "hz_stall_lus");
        step();
        exp_now(S_VALID, 1, "hz_stall_hold_valid");
        exp_now(S_MR, 1, "hz_stall_hold_mr");
        exp_now(S_RD, 32'd4, "hz_stall_hold_rd");
        step();
        flush = 1'b1;
        exp_now(S_LUS, 0, "flush_forces_lus0");
        step();
        exp_now(S_VALID, 0, "flush_valid");
        exp_now(S_MR, 0, "flush_mr");
        exp_now(S_RW, 0, "flush_rw");
        exp_now(S_CTR, 0, "flush_ctr");
        exp_now(S_LUS, 0, "flush_lus_after");
        flush = 1'b0; stall = 1'b0;

        // Store with forwarded rt
        drive_id("sw_r9", 1, 5'd1, 5'd9, 5'd0, 32'h200, 32'h1, 32'h10, 3'b000, 1, 0, 0, 1, 0);
        step();
        fwd(1, 5'd9, 32'h55, 0, 0, 0);
        exp_now(S_A, 32'h200, "sw_A");
        exp_now(S_B, 32'h10, "sw_B_imm");
        exp_now(S_SD, 32'h55, "sw_store_data");
        exp_now(S_MW, 1, "sw_mw");
        exp_now(S_RW, 0, "sw_rw");
        step();
        fwd(0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle
        drive_id("and_z", 1, 5'd3, 5'd5, 5'd12, 32'h1234, 32'h5678, 32'd0, 3'b001, 0, 1, 1, 0, 1);
        step();
        exp_now(S_VALID, 1, "pre_reset_valid");
        step();
        rst_n = 1'b0;
        $display("[cyc %0d] async reset asserted", cyc);
        exp_reset_state("midreset");
        step();
        rst_n = 1'b1;
        step();
        step();

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
